// File: rtl/bram_access_unit.sv
// Byte-addressed load/store front end for a single-port, word-wide, combinational-read BRAM.
// Optional macro BRAM_ACCESS_BOUNDS_CHECK_EN faults addresses at or above CAPACITY instead of wrapping.
module bram_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CAPACITY   = 1024,
  parameter int ADDR_WIDTH = $clog2((CAPACITY << 3) / DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  state_t                r_state;
  state_t                w_state_nxt;
  req_t                  r_req;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_err;
  logic [1:0]            w_lane;
  logic [NUM_LANES-1:0]  w_be;
  logic [31:0]           w_wrep;
  logic [31:0]           w_merged;
  logic [31:0]           w_shift;
  logic [31:0]           w_ext;
  logic                  w_unused;

  assign w_accept = req_valid && (r_state == S_IDLE) && rst_n;
  assign w_lane   = r_req.addr[1:0];
  assign w_unused = ^r_req.addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wen     = 1'b0;
    mem_din     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = rst_n;
        if (w_accept) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_din     = w_merged;
        mem_wen     = r_req.wen && !w_err && rst_n;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Faults are judged on the latched request, so they need not be held by the core.
  always_comb begin
    w_err = 1'b0;
    case (r_req.size)
      2'd0:    w_err = 1'b0;
      2'd1:    w_err = r_req.addr[0];
      2'd2:    w_err = |r_req.addr[1:0];
      default: w_err = 1'b1;
    endcase
`ifdef BRAM_ACCESS_BOUNDS_CHECK_EN
    if (r_req.addr >= 32'(CAPACITY)) w_err = 1'b1;
`endif
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign w_shift = mem_dout >> {w_lane, 3'b000};

  always_comb begin
    w_ext = mem_dout;
    case (r_req.size)
      2'd0:    w_ext = r_req.uns ? {24'd0, w_shift[7:0]}   : {{24{w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = r_req.uns ? {16'd0, w_shift[15:0]}  : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = mem_dout;
    endcase
  end

  // Store path: replicate the store data across lanes, then pick per lane
  // between new data and the current word (read-modify-write).
  always_comb begin
    w_be   = '1;
    w_wrep = r_req.wdata;
    case (r_req.size)
      2'd0: begin
        w_be   = 4'b0001 << w_lane;
        w_wrep = {4{r_req.wdata[7:0]}};
      end
      2'd1: begin
        w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_req.wdata[15:0]}};
      end
      default: begin
        w_be   = '1;
        w_wrep = r_req.wdata;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_merged[8*g +: 8] = w_be[g] ? w_wrep[8*g +: 8] : mem_dout[8*g +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.addr  <= req_addr;
        r_req.wen   <= req_wen;
        r_req.size  <= req_size;
        r_req.uns   <= req_unsigned;
        r_req.wdata <= req_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (!r_req.wen && !w_err) ? w_ext : 32'd0;
      end
    end
  end

  assign resp_rdata = resp_valid ? r_rdata : 32'd0;
  assign resp_err   = resp_valid && r_err;
  assign mem_addr   = r_req.addr[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_bram_access_unit.sv
// Self-checking bench for bram_access_unit: directed plan plus random traffic
// against a byte-array reference model of the memory.
module tb_bram_access_unit;

  localparam int CAP = 1024;
  localparam int AW  = 8;
  localparam int NW  = CAP / 4;

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] lit;
    logic        chk;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [31:0]   mem_din, mem_dout;

  logic [31:0]   bram     [0:NW-1];
  logic [31:0]   init_val [0:NW-1];
  logic [7:0]    ref_mem  [0:CAP-1];
  logic          preload;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_dout = bram[mem_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) bram[i] <= init_val[i];
    end else if (mem_wen) begin
      bram[mem_addr] <= mem_din;
    end
  end

  bram_access_unit #(.DATA_WIDTH(32), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Reference: byte-addressed memory, little-endian, aligned accesses only.
  function automatic void model(input logic [31:0] a, input logic w, input logic [1:0] sz,
                                input logic u, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    int ea;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea = int'(a & 32'(CAP - 1));
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef BRAM_ACCESS_BOUNDS_CHECK_EN
    if (a >= 32'(CAP)) er = 1'b1;
`endif
    rd = 32'd0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < n; i++) ref_mem[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ea + i]) << (8 * i));
      if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  // Drives one request and collects what the DUT did; k counts negedges after acceptance.
  task automatic drive(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int wcnt, output int wat, output int rdy_hi, output int hold_bad);
    int t;
    @(negedge clk);
    req_addr = a; req_wen = w; req_size = sz; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 10) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = -1; wcnt = 0; wat = -1; rdy_hi = 0; hold_bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mem_wen) begin wcnt++; if (wat < 0) wat = k; end
      if (req_ready) rdy_hi++;
      if (resp_valid) begin lat = k; break; end
    end
    rd = resp_rdata;
    er = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready || mem_wen) hold_bad++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int nbad;
    logic [31:0] exp_w;
    nbad = 0;
    for (int i = 0; i < NW; i++) begin
      exp_w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      if (bram[i] !== exp_w) nbad++;
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s mem_contents: %0d words differ, required 0", tag, nbad);
    end
  endtask

  // Runs a table of ops, checking each response against the model and optional literals.
  task automatic run_ops(input string tag, input op_t ops[], input logic chk_timing);
    logic [31:0] rd, m_rd;
    logic er, m_er;
    int lat, wcnt, wat, rdy, hb;
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i].a, ops[i].w, ops[i].sz, ops[i].u, ops[i].wd, 0, rd, er, lat, wcnt, wat, rdy, hb);
      model(ops[i].a, ops[i].w, ops[i].sz, ops[i].u, ops[i].wd, m_rd, m_er);
      total++;
      if (rd !== m_rd || er !== m_er) begin
        bad++;
        $display("FAIL %s[%0d] resp: got rdata=%h err=%b, required rdata=%h err=%b", tag, i, rd, er, m_rd, m_er);
      end
      if (ops[i].chk) begin
        total++;
        if (rd !== ops[i].lit) begin
          bad++;
          $display("FAIL %s[%0d] literal: got %h, required %h", tag, i, rd, ops[i].lit);
        end
      end
      if (chk_timing) begin
        total++;
        if (lat != 2 || rdy != 0 || wcnt != ((ops[i].w && !m_er) ? 1 : 0) ||
            wat != ((ops[i].w && !m_er) ? 1 : -1)) begin
          bad++;
          $display("FAIL %s[%0d] timing: got lat=%0d wen_cnt=%0d wen_at=%0d rdy=%0d, required lat=2 wen_cnt=%0d rdy=0",
                   tag, i, lat, wcnt, wat, rdy, (ops[i].w && !m_er) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_wen, mem_addr, mem_din} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h wen=%b addr=%h din=%h, required all 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_wen, mem_addr, mem_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b, required rdy=1 vld=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_word();
    op_t ops[];
    ops = new[2];
    ops[0] = '{32'h010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1};
    ops[1] = '{32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1};
    run_ops("word", ops, 1'b1);
  endtask

  task automatic test_extend();
    op_t ops[];
    ops = new[4];
    ops[0] = '{32'h013, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b1};
    ops[1] = '{32'h013, 1'b0, 2'd0, 1'b1, 32'h0, 32'h000000DE, 1'b1};
    ops[2] = '{32'h010, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b1};
    ops[3] = '{32'h010, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b1};
    run_ops("extend", ops, 1'b0);
  endtask

  task automatic test_partial();
    op_t ops[];
    ops = new[4];
    ops[0] = '{32'h011, 1'b1, 2'd0, 1'b0, 32'hAAAAAA55, 32'h0, 1'b1};
    ops[1] = '{32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD55EF, 1'b1};
    ops[2] = '{32'h012, 1'b1, 2'd1, 1'b0, 32'hBBBB1234, 32'h0, 1'b1};
    ops[3] = '{32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 32'h123455EF, 1'b1};
    run_ops("partial", ops, 1'b1);
  endtask

  task automatic test_errors();
    op_t ops[];
    ops = new[4];
    ops[0] = '{32'h011, 1'b1, 2'd1, 1'b0, 32'h00009999, 32'h0, 1'b1};
    ops[1] = '{32'h012, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1};
    ops[2] = '{32'h010, 1'b1, 2'd3, 1'b0, 32'h77777777, 32'h0, 1'b1};
    ops[3] = '{32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 32'h123455EF, 1'b1};
    run_ops("errors", ops, 1'b1);
    check_mem("errors");
  endtask

  task automatic test_bounds();
    op_t ops[];
    ops = new[2];
`ifdef BRAM_ACCESS_BOUNDS_CHECK_EN
    ops[0] = '{32'h400, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1};
    ops[1] = '{32'h000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0};
`else
    ops[0] = '{32'h400, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1};
    ops[1] = '{32'h000, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b1};
`endif
    run_ops("bounds", ops, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, m_rd;
    logic er, m_er;
    int lat, wcnt, wat, rdy, hb;
    drive(32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 5, rd, er, lat, wcnt, wat, rdy, hb);
    model(32'h010, 1'b0, 2'd2, 1'b0, 32'h0, m_rd, m_er);
    total++;
    if (hb != 0 || rd !== m_rd || er !== m_er) begin
      bad++;
      $display("FAIL backpressure: got unstable_cycles=%0d rdata=%h err=%b, required 0 %h %b", hb, rd, er, m_rd, m_er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, m_rd;
    logic er, m_er;
    int lat, wcnt, wat, rdy, hb;
    @(negedge clk);
    req_addr = 32'h020; req_wen = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h0BADF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_wen !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_access: got wen=%b rdy=%b, required 0 0", mem_wen, req_ready);
    end
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_wen, mem_addr, mem_din} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b vld=%b err=%b rdata=%h wen=%b addr=%h din=%h, required all 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_wen, mem_addr, mem_din);
    end
    rst_n = 1'b1;
    drive(32'h020, 1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat, wcnt, wat, rdy, hb);
    model(32'h020, 1'b0, 2'd2, 1'b0, 32'h0, m_rd, m_er);
    total++;
    if (rd !== m_rd || er !== m_er) begin
      bad++;
      $display("FAIL reset_mid_reload: got rdata=%h err=%b, required %h %b", rd, er, m_rd, m_er);
    end
    check_mem("reset_mid");
  endtask

  task automatic test_random();
    op_t ops[];
    logic [31:0] a;
    logic [1:0] sz;
    ops = new[60];
    for (int i = 0; i < 60; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
      ops[i] = '{a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, 32'h0, 1'b0};
    end
    run_ops("random", ops, 1'b1);
    check_mem("random");
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < NW; i++) begin
      init_val[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_val[i][8*b +: 8];
    end
    @(posedge clk);
    #1 preload = 1'b0;
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_errors();
    test_bounds();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_access_unit.md
# bram_access_unit

Request-side controller for the single-port, word-wide, combinational-read BRAM. It accepts byte-addressed load/store requests from a core over a valid/ready handshake and drives the BRAM's word address, write enable and write data. Sub-word stores run as read-modify-write, because the BRAM has no byte enables. Loads are returned sign- or zero-extended on a valid/ready response channel.

## Interface
Parameters:
- DATA_WIDTH, 32, BRAM word width; only 32 is supported.
- CAPACITY, 1024, BRAM capacity in bytes; must match the attached BRAM.
- ADDR_WIDTH, $clog2((CAPACITY<<3)/DATA_WIDTH), BRAM word-address width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  zero-extend load (ignored for stores and word loads)
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request faulted
- mem_addr  out  ADDR_WIDTH  BRAM word address
- mem_wen  out  1  BRAM write enable
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data, combinational from mem_addr

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: one cycle; memory is read and/or written.
  - RESP: resp_valid=1.
- IDLE→ACCESS on req_valid&&req_ready. All request fields are latched at that edge.
- ACCESS→RESP unconditionally. RESP→IDLE on resp_ready.
- Word index = addr[ADDR_WIDTH+1:2]. Byte lane = addr[1:0]. Little-endian.
- Error conditions: size=3; half with addr[0]=1; word with addr[1:0]≠0. Errors are detected on latched fields.
- Error behaviour: mem_wen=0, resp_err=1, resp_rdata=0.
- Load in ACCESS:
  - Select the lane from mem_dout.
  - Extend: byte to 32 bits (sign from bit 7 unless unsigned); half likewise from bit 15.
  - Register the result into resp_rdata.
- Store in ACCESS:
  - mem_wen=1.
  - mem_din = mem_dout with the addressed byte/half lanes replaced by req_wdata[7:0]/[15:0]; word stores use req_wdata directly.
  - The BRAM commits at the ACCESS→RESP edge.
- mem_addr holds the latched word index in all states; mem_din=0 outside ACCESS.
- mem_wen is combinational: (state==ACCESS)&&store&&!err&&rst_n. A reset sampled during ACCESS suppresses the write.
- The write is visible to any later request. No forwarding is needed because only one request is ever in flight.

## Timing
- Reset values: req_ready=0 while rst_n=0, then 1 in IDLE. resp_valid=0, resp_err=0, resp_rdata=0, mem_wen=0, mem_addr=0, mem_din=0. State=IDLE.
- Latency: request accepted at edge E0; resp_valid rises after edge E1 (2 cycles); a store is committed at E1.
- Throughput: at most one request per 3 cycles (IDLE, ACCESS, RESP).
- Backpressure: in RESP, resp_valid, resp_rdata and resp_err hold stable until resp_ready; req_ready=0 throughout.
- req_valid without req_ready is ignored; request fields need not be held after acceptance.
- Reset mid-operation (any state): return to IDLE, drop the response, perform no write.

## Configuration
- BRAM_ACCESS_BOUNDS_CHECK_EN defined:
  - req_addr ≥ CAPACITY (including any nonzero bits above ADDR_WIDTH+1) is an error.
  - Error behaviour: no write, resp_err=1, rdata=0.
- Undefined: upper address bits are ignored; the access wraps modulo CAPACITY.

## Test plan
- Word store 0xDEADBEEF @0x010, then word load @0x010 → rdata=0xDEADBEEF, err=0. mem_wen high exactly one cycle, at 1 cycle after acceptance.
- After the above:
  - signed byte load @0x013 → 0xFFFFFFDE
  - unsigned byte @0x013 → 0x000000DE
  - unsigned half @0x010 → 0x0000BEEF
  - signed half @0x010 → 0xFFFFBEEF
- Byte store 0x55 @0x011, then word load @0x010 → 0xDEAD55EF. Half store 0x1234 @0x012, then word load @0x010 → 0x123455EF.
- Faulting requests, each → resp_err=1, rdata=0, memory unchanged, mem_wen never high:
  - misaligned half store @0x011
  - word load @0x012
  - size=3
- With CAPACITY=1024, word store 0xCAFEF00D @0x400, then word load @0x000:
  - macro defined → store err=1, load returns prior contents.
  - macro undefined → store err=0, load returns 0xCAFEF00D.
- Hold resp_ready=0 for 5 cycles on a load response → resp fields stable, req_ready=0. Then assert rst_n=0 during ACCESS of a word store to @0x020 → no write, outputs at reset values, and a later load @0x020 returns the old value.
